// File: rtl/mem_rd_pkg.sv
// Shared types and sizing for the burst read engine.
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/mem_burst_reader_if.sv
// Control, RAM read port and output stream of the burst reader; master = engine side.
interface mem_burst_reader_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  start, base_addr, len, rd_data, out_ready,
        output busy, done, rd_addr, out_data, out_valid
    );

    modport slave (
        output start, base_addr, len, rd_data, out_ready,
        input  busy, done, rd_addr, out_data, out_valid
    );
endinterface

// File: rtl/mem_rd_skid.sv
// 2-entry registered FIFO; the head register drives the output stream directly.
// Latency: push visible at the head one cycle later when empty.
// Backpressure: head holds while not popped; caller must never push when full.
module mem_rd_skid
    import mem_rd_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic [SKID_CNT_W-1:0] count,
    output logic [DW-1:0]         head_data,
    output logic                  head_valid
);

    logic [DW-1:0] tail_data;
    logic          tail_valid;

    assign count = SKID_CNT_W'(head_valid) + SKID_CNT_W'(tail_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!head_valid) begin
                        head_data  <= push_data;
                        head_valid <= 1'b1;
                    end else begin
                        tail_data  <= push_data;
                        tail_valid <= 1'b1;
                    end
                end
                2'b01: begin
                    if (tail_valid) begin
                        head_data  <= tail_data;
                        tail_valid <= 1'b0;
                    end else begin
                        head_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    // pop implies the head is occupied, so the new word slots in behind it
                    if (tail_valid) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine: streams len consecutive RAM words starting at base_addr.
// Latency: start to first out_valid 3 cycles, then one word per cycle.
// Backpressure: read issue stalls in-cycle on skid occupancy; 2-entry skid absorbs the in-flight word.
module mem_burst_reader
    import mem_rd_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_burst_reader_if.master bus
);

    localparam int OCC_W = SKID_CNT_W + 1;

    state_t                  state;
    logic [AW-1:0]           rd_addr_q;
    logic [AW:0]             remaining;
    logic                    inflight;
    logic                    busy_q;
    logic                    done_q;
    logic [SKID_CNT_W-1:0]   buf_count;
    logic [DW-1:0]           head_data;
    logic                    head_valid;
    logic                    pop;
    logic                    issue;
    logic                    finishing;
    logic [OCC_W-1:0]        occ;

    assign pop = head_valid && bus.out_ready;

    // Occupancy the skid will have next cycle before any new capture; one slot must stay free.
    assign occ   = OCC_W'(buf_count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = (state == READ) && (occ <= OCC_W'(SKID_DEPTH - 1));

    assign finishing = (state == DRAIN) && !done_q && !inflight &&
                       ((buf_count == '0) || ((buf_count == SKID_CNT_W'(1)) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr_q <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= READ;
                            busy_q    <= 1'b1;
                            rd_addr_q <= bus.base_addr;
                            remaining <= bus.len;
                        end
                    end
                end
                READ: begin
                    // rd_addr already presents the address being issued this cycle
                    if (issue) begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        if (remaining == (AW+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (finishing) begin
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rd_skid #(.DW(DW)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (bus.rd_data),
        .pop        (pop),
        .count      (buf_count),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_data  = head_data;
    assign bus.out_valid = head_valid;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: RAM model, queue-based reference of the expected stream, per-cycle compare.
module tb_mem_burst_reader;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_burst_reader_if #(.AW(AW), .DW(DW)) bus ();
    mem_burst_reader #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: each accepted burst enqueues mem[(base+i) mod 256]; done follows the last handshake.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    bit            armed = 1'b0;
    bit            busy_on = 1'b0;
    int            done_at = -1;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data;

    always @(negedge clk) begin
        if (armed) begin
            check("busy", bus.busy, busy_on);
            check("done", bus.done, cyc == done_at);
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, stall_data);
            end
            if (bus.out_valid) begin
                check("extra_word", exp_q.size() != 0, 1);
                if (bus.out_ready) begin
                    got_q.push_back(bus.out_data);
                    if (exp_q.size() != 0) begin
                        check("out_data", bus.out_data, exp_q[0]);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_at = cyc + 1;
                    end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            if (rst) begin
                exp_q.delete();
                busy_on    = 1'b0;
                done_at    = -1;
                stall_prev = 1'b0;
            end else begin
                if (bus.start && !busy_on) begin
                    if (bus.len == 0) begin
                        done_at = cyc + 1;
                    end else begin
                        for (int i = 0; i < int'(bus.len); i++)
                            exp_q.push_back(mem[(int'(bus.base_addr) + i) % 256]);
                        busy_on = 1'b1;
                    end
                end else if (cyc == done_at) begin
                    busy_on = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int n);
        case (mode)
            0: return 1'b1;
            1: return n[0];
            2: return ($urandom_range(0, 3) != 0);
            default: return !((n % 2 == 1) || (n >= 6 && n < 11));
        endcase
    endfunction

    task automatic run_burst(input logic [7:0] base, input logic [8:0] n_words,
                             input int mode, input bit poke);
        bit seen = 1'b0;
        got_q.delete();
        tick();
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.len       = n_words;
        bus.out_ready = ready_for(mode, 0);
        tick();
        bus.start = 1'b0;
        for (int n = 1; n < 3000 && !seen; n++) begin
            bus.out_ready = ready_for(mode, n);
            if (poke && n == 3) begin
                bus.start     = 1'b1;
                bus.base_addr = base + 8'h40;
                bus.len       = 9'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else tick();
        end
        check("burst_done_seen", seen, 1);
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    logic [DW-1:0] wrap_exp [4];

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        rst   = 1'b0;
        armed = 1'b1;

        // Cycle-exact pins: base 0x10, len 4, ready high
        tick();
        bus.start = 1'b1; bus.base_addr = 8'h10; bus.len = 9'd4;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("t1_busy", bus.busy, 1);
        check("t1_rd_addr", bus.rd_addr, 8'h10);
        tick();
        @(negedge clk);
        check("t2_valid", bus.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t3_valid", bus.out_valid, 1);
            check("t3_data", bus.out_data, 32'h110 + i);
        end
        tick();
        @(negedge clk);
        check("t7_done", bus.done, 1);
        tick();

        // Address wrap
        run_burst(8'hFE, 9'd4, 0, 1'b0);
        wrap_exp = '{32'h1FE, 32'h1FF, 32'h100, 32'h101};
        check("wrap_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("wrap_data", got_q[i], wrap_exp[i]);

        // Zero-length burst
        tick();
        bus.start = 1'b1; bus.base_addr = 8'h22; bus.len = 9'd0;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("len0_done", bus.done, 1);
        check("len0_busy", bus.busy, 0);
        check("len0_valid", bus.out_valid, 0);
        tick();
        @(negedge clk);
        check("len0_done_clear", bus.done, 0);
        tick();

        // Alternating ready with a 5-cycle stall
        run_burst(8'h30, 9'd8, 3, 1'b0);
        check("stall_count", got_q.size(), 8);

        // Start while busy is ignored
        run_burst(8'h50, 9'd12, 1, 1'b1);
        check("poke_count", got_q.size(), 12);
        if (got_q.size() == 12) begin
            check("poke_first", got_q[0], 32'h150);
            check("poke_last", got_q[11], 32'h15B);
        end

        // Reset mid-burst
        tick();
        bus.start = 1'b1; bus.base_addr = 8'h80; bus.len = 9'd16;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            bus.out_ready = ready_for(2, n);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        run_burst(8'h80, 9'd16, 2, 1'b0);
        check("post_rst_count", got_q.size(), 16);

        // Randomised bursts over random memory contents
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] b;
            logic [8:0] l;
            int         m;
            b = 8'($urandom);
            l = 9'($urandom_range(0, 40));
            m = int'($urandom_range(0, 3));
            run_burst(b, l, m, (l > 9'd6) && (k % 3 == 0));
            check("rand_count", got_q.size(), l);
        end

        // Full address space
        run_burst(8'h7F, 9'd256, 2, 1'b0);
        check("full_count", got_q.size(), 256);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
